// File: rtl/variable_bounds_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : variable_bounds_accumulator
// Brief    : Intersects per-clause (+/-)y <= b bounds into one feasible
//            interval per variable frame. Optional VARIABLE_BOUNDS_ACTIVE_COUNT_EN
//            compiles in the active-clause counter.
// Revision : 1.0 - initial release
// ============================================================================
module variable_bounds_accumulator #(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT  = 8,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX = 4
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset_n,
    input  logic                                          in_start,
    input  logic                                          in_clause_valid,
    input  logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_bias,
    input  logic                                          in_sign,
    input  logic                                          in_active,
    input  logic                                          in_last,
    output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   out_lower,
    output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT:0]   out_upper,
    output logic                                          out_empty,
    output logic                                          out_valid,
    output logic                                          out_busy,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0]    out_active_count
);

    localparam int W = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int N = MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX;

    localparam logic signed [W:0] c_lower_init = {2'b11, {(W-1){1'b0}}};
    localparam logic signed [W:0] c_upper_init = {2'b00, {(W-1){1'b1}}};
    localparam logic [N:0]        c_last_idx   = (N+1)'((1 << N) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic signed [W:0]   lower_q, lower_d;
    logic signed [W:0]   upper_q, upper_d;
    logic [N:0]          clause_cnt_q, clause_cnt_d;

    logic signed [W:0]   w_bias_ext;
    logic signed [W:0]   w_neg_bias;
    logic                w_accept;

    // One extra bit makes the negation of the most negative bias exact.
    assign w_bias_ext = {in_bias[W-1], in_bias};
    assign w_neg_bias = -w_bias_ext;
    assign w_accept   = (state_q == ST_ACCUM) && in_clause_valid && !in_start;

    always_comb begin
        state_d      = state_q;
        lower_d      = lower_q;
        upper_d      = upper_q;
        clause_cnt_d = clause_cnt_q;

        if (in_start) begin
            state_d      = ST_ACCUM;
            lower_d      = c_lower_init;
            upper_d      = c_upper_init;
            clause_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_clause_valid) begin
                        clause_cnt_d = clause_cnt_q + (N+1)'(1);
                        if (in_active) begin
                            if (in_sign) begin
                                if (w_bias_ext < upper_q) upper_d = w_bias_ext;
                            end else begin
                                if (w_neg_bias > lower_q) lower_d = w_neg_bias;
                            end
                        end
                        if (in_last || (clause_cnt_q == c_last_idx)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state_q      <= ST_IDLE;
            lower_q      <= '0;
            upper_q      <= '0;
            clause_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lower_q      <= lower_d;
            upper_q      <= upper_d;
            clause_cnt_q <= clause_cnt_d;
        end
    end

`ifdef VARIABLE_BOUNDS_ACTIVE_COUNT_EN
    logic [N:0] active_cnt_q, active_cnt_d;

    always_comb begin
        active_cnt_d = active_cnt_q;
        if (in_start) begin
            active_cnt_d = '0;
        end else if (w_accept && in_active) begin
            active_cnt_d = active_cnt_q + (N+1)'(1);
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            active_cnt_q <= '0;
        end else begin
            active_cnt_q <= active_cnt_d;
        end
    end

    assign out_active_count = active_cnt_q;
`else
    assign out_active_count = '0;
`endif

    assign out_lower = lower_q;
    assign out_upper = upper_q;
    assign out_empty = (lower_q > upper_q);
    assign out_valid = (state_q == ST_DONE);
    assign out_busy  = (state_q == ST_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_variable_bounds_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_variable_bounds_accumulator
// Brief    : Scenario tasks plus randomized frames against an interval model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_variable_bounds_accumulator;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        int b;
        bit s;
        bit a;
        bit l;
    } clause_t;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic                cvalid;
    logic signed [W-1:0] bias;
    logic                sign;
    logic                active;
    logic                last;
    logic signed [W:0]   lower;
    logic signed [W:0]   upper;
    logic                empty;
    logic                valid;
    logic                busy;
    logic [N:0]          act_cnt;

    int checks = 0;
    int errors = 0;

    variable_bounds_accumulator #(
        .MAXIMUM_BIT_WIDTH_OF_COEFFICIENT (W),
        .MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX(N)
    ) dut (
        .in_clk          (clk),
        .in_reset_n      (reset_n),
        .in_start        (start),
        .in_clause_valid (cvalid),
        .in_bias         (bias),
        .in_sign         (sign),
        .in_active       (active),
        .in_last         (last),
        .out_lower       (lower),
        .out_upper       (upper),
        .out_empty       (empty),
        .out_valid       (valid),
        .out_busy        (busy),
        .out_active_count(act_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input bit st, input bit v, input int b, input bit s, input bit a, input bit l);
        start  = st;
        cvalid = v;
        bias   = W'(b);
        sign   = s;
        active = a;
        last   = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Interval intersection over the frame; the 2**N-th clause ends it implicitly.
    task automatic model(input clause_t q[$], output int lo, output int hi, output int cnt, output bit emp);
        lo  = -(1 << (W-1));
        hi  = (1 << (W-1)) - 1;
        cnt = 0;
        for (int i = 0; i < q.size() && i < (1 << N); i++) begin
            if (q[i].a) begin
                cnt++;
                if (q[i].s) hi = (q[i].b < hi) ? q[i].b : hi;
                else        lo = (-q[i].b > lo) ? -q[i].b : lo;
            end
            if (q[i].l) break;
        end
`ifndef VARIABLE_BOUNDS_ACTIVE_COUNT_EN
        cnt = 0;
`endif
        emp = (lo > hi);
    endtask

    task automatic run_frame(input clause_t q[$]);
        cyc(1, 0, 0, 0, 0, 0);
        foreach (q[i]) cyc(0, 1, q[i].b, q[i].s, q[i].a, q[i].l);
    endtask

    // Checks the DONE cycle against the model, then the held values one cycle later.
    task automatic check_done(input string nm, input clause_t q[$]);
        int lo, hi, cnt;
        bit emp;
        model(q, lo, hi, cnt, emp);
        for (int k = 0; k < 2; k++) begin
            checks++; if (valid !== (k == 0)) begin errors++; $display("FAIL %s valid[%0d] got %b want %b", nm, k, valid, (k == 0)); end
            checks++; if (lower !== lo) begin errors++; $display("FAIL %s lower[%0d] got %0d want %0d", nm, k, lower, lo); end
            checks++; if (upper !== hi) begin errors++; $display("FAIL %s upper[%0d] got %0d want %0d", nm, k, upper, hi); end
            checks++; if (empty !== emp) begin errors++; $display("FAIL %s empty[%0d] got %b want %b", nm, k, empty, emp); end
            checks++; if (act_cnt !== cnt) begin errors++; $display("FAIL %s count[%0d] got %0d want %0d", nm, k, act_cnt, cnt); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy[%0d] got %b want 0", nm, k, busy); end
            idle();
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({lower, upper, act_cnt, empty, valid, busy} !== '0) begin
            errors++;
            $display("FAIL %s got lo=%0d hi=%0d cnt=%0d e=%b v=%b b=%b want all 0",
                     nm, lower, upper, act_cnt, empty, valid, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(); idle();
        check_zero("reset_initial");
        reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        cyc(0, 1, 5, 1, 1, 0);
        reset_n = 1'b0;
        idle(); idle();
        check_zero("reset_midframe");
        reset_n = 1'b1;
        cyc(0, 1, 3, 1, 1, 1);
        idle();
        check_zero("reset_idle_clause");
    endtask

    task automatic test_mixed();
        clause_t q[$];
        q = '{'{5, 1, 1, 0}, '{2, 0, 1, 0}, '{9, 1, 1, 1}};
        run_frame(q);
        check_done("mixed", q);
    endtask

    task automatic test_all_inactive();
        clause_t q[$];
        q = '{'{-7, 1, 0, 0}, '{20, 0, 0, 0}, '{1, 1, 0, 1}};
        run_frame(q);
        check_done("inactive", q);
    endtask

    task automatic test_negation();
        clause_t q[$];
        q = '{'{-128, 0, 1, 1}};
        run_frame(q);
        checks++; if (lower !== 9'sd128) begin errors++; $display("FAIL negation_lower got %0d want 128", lower); end
        check_done("negation", q);
    endtask

    task automatic test_restart();
        clause_t q[$];
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 1, 1, 0);
        cyc(1, 1, 1, 1, 1, 0);
        cyc(0, 1, 50, 1, 1, 1);
        q = '{'{50, 1, 1, 1}};
        check_done("restart", q);
    endtask

    task automatic test_implicit_last();
        clause_t q[$];
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            q.push_back('{10, 1, 1, 0});
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL implicit_busy[%0d] got %b want 1", i, busy); end
            cyc(0, 1, 10, 1, 1, 0);
        end
        // The extra clauses arrive during DONE and then IDLE and must be dropped.
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL implicit_valid got %b want 1", valid); end
        cyc(0, 1, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        checks++; if (upper !== 9'sd10) begin errors++; $display("FAIL implicit_upper got %0d want 10", upper); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL implicit_valid_after got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL implicit_busy_after got %b want 0", busy); end
        q.push_back('{1, 1, 1, 0});
        cyc(1, 0, 0, 0, 0, 0);
        foreach (q[i]) if (i < 16) cyc(0, 1, q[i].b, q[i].s, q[i].a, q[i].l);
        check_done("implicit", q);
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            clause_t q[$];
            int len;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                clause_t c;
                c.b = int'($urandom_range(0, 255)) - 128;
                c.s = 1'($urandom_range(0, 1));
                c.a = ($urandom_range(0, 3) != 0);
                c.l = (i == len - 1) && (len < 16 || $urandom_range(0, 1) == 1);
                q.push_back(c);
            end
            cyc(1, 0, 0, 0, 0, 0);
            foreach (q[i]) begin
                cyc(0, 1, q[i].b, q[i].s, q[i].a, q[i].l);
                // Occasional idle gaps between clauses must not disturb the frame.
                if (i != len - 1 && $urandom_range(0, 4) == 0) idle();
            end
            check_done($sformatf("random%0d", f), q);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        cvalid  = 1'b0;
        bias    = '0;
        sign    = 1'b0;
        active  = 1'b0;
        last    = 1'b0;
        @(negedge clk);
        test_reset();
        test_mixed();
        test_all_inactive();
        test_negation();
        test_restart();
        test_implicit_last();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
